// File: rtl/bitty_core_p.sv
// bitty_core_p: parametrised multi-cycle Bitty execution core.
// Each instruction goes FETCH -> EXEC -> (MEM) -> WB. It accepts 16-bit
// instructions over a valid/ready handshake, keeps a program counter with
// conditional branches, and talks to memory through a req/ack port.
module bitty_core_p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [PC_W-1:0]   pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] d_out,
    output logic              done
);

    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Architectural and pipeline-holding state
    logic [DATA_W-1:0] regs [8];
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic [PC_W-1:0]   pc_next_q;

    // Fields decoded from the latched instruction
    logic [2:0] rx_q;
    logic [7:0] imm8_q;
    logic [2:0] sel_q;
    logic [1:0] fmt_q;

    // Combinational datapath values
    logic              accept;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              taken;
    logic [PC_W-1:0]   imm_sext;
    logic              is_store;
    logic              writes_reg;

    assign rx_q   = instr_q[15:13];
    assign imm8_q = instr_q[12:5];
    assign sel_q  = instr_q[4:2];
    assign fmt_q  = instr_q[1:0];

    assign accept     = instr_valid && (state == FETCH);
    assign imm_sext   = PC_W'($signed(imm8_q));
    assign is_store   = (fmt_q == 2'd3) && sel_q[0];
    assign writes_reg = (fmt_q != 2'd2) && !is_store;

    // State register; reset returns to FETCH from anywhere, even mid-memory access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded handshake/memory outputs
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        done        = 1'b0;
        case (state)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (fmt_q == 2'd3) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_we    = sel_q[0];
                mem_addr  = b_q[ADDR_W-1:0];
                mem_wdata = a_q;
                if (mem_ack) begin
                    state_next = WB;
                end
            end
            WB: begin
                done       = 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // ALU: second operand is Ry for register format, zero-extended imm8 otherwise
    always_comb begin
        alu_b = (fmt_q == 2'd1) ? DATA_W'(imm8_q) : b_q;
        alu_y = '0;
        case (sel_q)
            3'd0: alu_y = a_q + alu_b;
            3'd1: alu_y = a_q - alu_b;
            3'd2: alu_y = a_q & alu_b;
            3'd3: alu_y = a_q | alu_b;
            3'd4: alu_y = a_q ^ alu_b;
            3'd5: alu_y = a_q << alu_b[SH_W-1:0];
            3'd6: alu_y = a_q >> alu_b[SH_W-1:0];
            3'd7: alu_y = {{(DATA_W-1){1'b0}}, (a_q < alu_b)};
            default: alu_y = '0;
        endcase
    end

    // Branch condition evaluated on the latched Rx value
    always_comb begin
        taken = 1'b0;
        case (sel_q)
            3'd0: taken = 1'b1;
            3'd1: taken = (a_q == '0);
            3'd2: taken = (a_q != '0);
            3'd3: taken = a_q[DATA_W-1];
            default: taken = 1'b0;
        endcase
    end

    // Datapath: latch on accept, compute in EXEC, capture load data on ack, commit in WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            pc_next_q <= '0;
            pc        <= '0;
            d_out     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        instr_q <= instr;
                        a_q     <= regs[instr[15:13]];
                        b_q     <= regs[instr[12:10]];
                    end
                end
                EXEC: begin
                    if (fmt_q == 2'd3) begin
                        result_q <= a_q;
                    end else begin
                        result_q <= alu_y;
                    end
                    if ((fmt_q == 2'd2) && taken) begin
                        pc_next_q <= pc + imm_sext;
                    end else begin
                        pc_next_q <= pc + PC_W'(1);
                    end
                end
                MEM: begin
                    if (mem_ack && !sel_q[0]) begin
                        result_q <= mem_rdata;
                    end
                end
                WB: begin
                    pc <= pc_next_q;
                    if (fmt_q != 2'd2) begin
                        d_out <= result_q;
                    end
                    if (writes_reg) begin
                        regs[rx_q] <= result_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_core_p.sv
// tb_bitty_core_p: directed-vector bench for bitty_core_p (DATA_W=16, ADDR_W=8, PC_W=8).
// A small memory responder with programmable ack delay answers the memory port.
module tb_bitty_core_p;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] d_out;
    logic        done;

    logic        resp_ack;
    logic        stray_ack;
    logic        resp_enable;
    int          ack_delay;
    int          req_age;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] mem_model [256];

    int vectors;
    int miscompares;

    assign mem_ack = resp_ack | stray_ack;

    bitty_core_p #(
        .DATA_W(16),
        .ADDR_W(8),
        .PC_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .d_out      (d_out),
        .done       (done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and tally the result
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] encR(input logic [2:0] rx, input logic [2:0] ry,
                                         input logic [2:0] sel, input logic [1:0] fmt);
        return {rx, ry, 5'b00000, sel, fmt};
    endfunction

    function automatic logic [15:0] encI(input logic [2:0] rx, input logic [7:0] imm,
                                         input logic [2:0] sel, input logic [1:0] fmt);
        return {rx, imm, sel, fmt};
    endfunction

    // Memory responder: acks ack_delay cycles after mem_req rises and checks the held request
    initial begin
        resp_ack  = 1'b0;
        mem_rdata = '0;
        req_age   = 0;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = '0;
        end
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (mem_req && resp_enable) begin
                checkOutput("mem_we", mem_we, exp_we);
                checkOutput("mem_addr", mem_addr, exp_addr);
                checkOutput("mem_wdata", mem_wdata, exp_wdata);
                if (req_age == ack_delay) begin
                    resp_ack = 1'b1;
                    if (mem_we) begin
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_model[mem_addr];
                    end
                    req_age = 0;
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // Present one instruction and hold it until the accepting edge
    task automatic issueInstr(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
    endtask

    // Count cycles after acceptance until done, bounded so a stuck core still ends
    task automatic waitDone(input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        checkOutput("latency", n, exp_lat);
    endtask

    // Run one instruction to completion and check the committed state in the following FETCH
    task automatic applyStimulus(input string tag, input logic [15:0] w, input int exp_lat,
                                 input logic [15:0] exp_dout, input logic [7:0] exp_pc);
        issueInstr(w);
        waitDone(exp_lat);
        @(negedge clk);
        checkOutput({tag, "_dout"}, d_out, exp_dout);
        checkOutput({tag, "_pc"}, pc, exp_pc);
        checkOutput({tag, "_done_pulse"}, done, 1'b0);
        checkOutput({tag, "_ready"}, instr_ready, 1'b1);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        stray_ack   = 1'b0;
        resp_enable = 1'b1;
        ack_delay   = 0;
        exp_we      = 1'b0;
        exp_addr    = '0;
        exp_wdata   = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_pc", pc, 8'h00);
        checkOutput("rst_dout", d_out, 16'h0000);
        checkOutput("rst_req", mem_req, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", instr_ready, 1'b1);
        checkOutput("rst_addr", mem_addr, 8'h00);
        checkOutput("rst_wdata", mem_wdata, 16'h0000);

        // Immediate and register adds, 3 cycles each
        applyStimulus("addi_r1", encI(3'd1, 8'h05, 3'd0, 2'd1), 2, 16'h0005, 8'h01);
        applyStimulus("addi_r2", encI(3'd2, 8'hFF, 3'd0, 2'd1), 2, 16'h00FF, 8'h02);
        applyStimulus("add_r1r2", encR(3'd1, 3'd2, 3'd0, 2'd0), 2, 16'h0104, 8'h03);

        // Remaining ALU operations
        applyStimulus("addi_r3", encI(3'd3, 8'hF0, 3'd0, 2'd1), 2, 16'h00F0, 8'h04);
        applyStimulus("subi_r3", encI(3'd3, 8'hF1, 3'd1, 2'd1), 2, 16'hFFFF, 8'h05);
        applyStimulus("shli_r3", encI(3'd3, 8'h09, 3'd5, 2'd1), 2, 16'hFE00, 8'h06);
        applyStimulus("sltui_f", encI(3'd3, 8'hFF, 3'd7, 2'd1), 2, 16'h0000, 8'h07);
        applyStimulus("andi_r1", encI(3'd1, 8'h0C, 3'd2, 2'd1), 2, 16'h0004, 8'h08);
        applyStimulus("ori_r1", encI(3'd1, 8'hF0, 3'd3, 2'd1), 2, 16'h00F4, 8'h09);
        applyStimulus("xori_r1", encI(3'd1, 8'hFF, 3'd4, 2'd1), 2, 16'h000B, 8'h0A);
        applyStimulus("shri_r2", encI(3'd2, 8'h04, 3'd6, 2'd1), 2, 16'h000F, 8'h0B);
        applyStimulus("sltui_t", encI(3'd2, 8'h10, 3'd7, 2'd1), 2, 16'h0001, 8'h0C);
        applyStimulus("sub_r3r2", encR(3'd3, 3'd2, 3'd1, 2'd0), 2, 16'hFFFF, 8'h0D);

        // Branches: r4 = 0, r3 = 0xFFFF; d_out must stay 0xFFFF
        applyStimulus("br_z_t", encI(3'd4, 8'hFE, 3'd1, 2'd2), 2, 16'hFFFF, 8'h0B);
        applyStimulus("br_nz_nt", encI(3'd4, 8'hFE, 3'd2, 2'd2), 2, 16'hFFFF, 8'h0C);
        applyStimulus("br_neg_t", encI(3'd3, 8'h05, 3'd3, 2'd2), 2, 16'hFFFF, 8'h11);
        applyStimulus("br_never", encI(3'd4, 8'h05, 3'd4, 2'd2), 2, 16'hFFFF, 8'h12);
        applyStimulus("br_al_1", encI(3'd0, 8'h7F, 3'd0, 2'd2), 2, 16'hFFFF, 8'h91);
        applyStimulus("br_al_wrap", encI(3'd0, 8'h7F, 3'd0, 2'd2), 2, 16'hFFFF, 8'h10);
        applyStimulus("br_nz_t", encI(3'd3, 8'h80, 3'd2, 2'd2), 2, 16'hFFFF, 8'h90);
        applyStimulus("br_neg_nt", encI(3'd4, 8'h80, 3'd3, 2'd2), 2, 16'hFFFF, 8'h91);

        // Build r5 = 0xBEEF and r6 = 0x12
        applyStimulus("addi_r5", encI(3'd5, 8'hBE, 3'd0, 2'd1), 2, 16'h00BE, 8'h92);
        applyStimulus("shli_r5", encI(3'd5, 8'h08, 3'd5, 2'd1), 2, 16'hBE00, 8'h93);
        applyStimulus("ori_r5", encI(3'd5, 8'hEF, 3'd3, 2'd1), 2, 16'hBEEF, 8'h94);
        applyStimulus("addi_r6", encI(3'd6, 8'h12, 3'd0, 2'd1), 2, 16'h0012, 8'h95);

        // Store with a 3-cycle ack delay: WB lands 6 cycles after accept
        ack_delay = 3;
        exp_we    = 1'b1;
        exp_addr  = 8'h12;
        exp_wdata = 16'hBEEF;
        applyStimulus("store", encR(3'd5, 3'd6, 3'd1, 2'd3), 6, 16'hBEEF, 8'h96);
        applyStimulus("addi_r1_0", encI(3'd1, 8'h00, 3'd0, 2'd1), 2, 16'h000B, 8'h97);

        // Load with immediate ack: 4 cycles; r7 is 0 so wdata shows 0
        ack_delay = 0;
        exp_we    = 1'b0;
        exp_addr  = 8'h12;
        exp_wdata = 16'h0000;
        applyStimulus("load", encR(3'd7, 3'd6, 3'd0, 2'd3), 3, 16'hBEEF, 8'h98);
        applyStimulus("addi_r2_0", encI(3'd2, 8'h00, 3'd0, 2'd1), 2, 16'h0001, 8'h99);
        applyStimulus("readback_r7", encI(3'd7, 8'h00, 3'd0, 2'd1), 2, 16'hBEEF, 8'h9A);

        // Idle in FETCH for 5 cycles: nothing moves
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle_ready", instr_ready, 1'b1);
            checkOutput("idle_done", done, 1'b0);
            checkOutput("idle_pc", pc, 8'h9A);
            checkOutput("idle_dout", d_out, 16'hBEEF);
        end
        applyStimulus("readback_r5", encI(3'd5, 8'h00, 3'd0, 2'd1), 2, 16'hBEEF, 8'h9B);
        applyStimulus("sltu_t", encR(3'd2, 3'd7, 3'd7, 2'd0), 2, 16'h0001, 8'h9C);
        applyStimulus("sltu_f", encR(3'd7, 3'd2, 3'd7, 2'd0), 2, 16'h0000, 8'h9D);

        // Reset while a store waits in MEM with no ack coming
        resp_enable = 1'b0;
        exp_we      = 1'b1;
        exp_addr    = 8'h12;
        exp_wdata   = 16'hBEEF;
        issueInstr(encR(3'd5, 3'd6, 3'd1, 2'd3));
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_req", mem_req, 1'b1);
        checkOutput("mid_we", mem_we, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rmem_req", mem_req, 1'b0);
        checkOutput("rmem_we", mem_we, 1'b0);
        checkOutput("rmem_done", done, 1'b0);
        checkOutput("rmem_addr", mem_addr, 8'h00);
        checkOutput("rmem_wdata", mem_wdata, 16'h0000);
        @(negedge clk);
        reset       = 1'b0;
        resp_enable = 1'b1;
        @(negedge clk);
        checkOutput("rel_pc", pc, 8'h00);
        checkOutput("rel_dout", d_out, 16'h0000);
        checkOutput("rel_ready", instr_ready, 1'b1);

        // A stray ack in FETCH is ignored
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        @(negedge clk);
        checkOutput("stray_ready", instr_ready, 1'b1);
        checkOutput("stray_done", done, 1'b0);
        checkOutput("stray_req", mem_req, 1'b0);
        checkOutput("stray_pc", pc, 8'h00);

        // Registers were cleared by reset
        applyStimulus("post_r1", encI(3'd1, 8'h03, 3'd0, 2'd1), 2, 16'h0003, 8'h01);
        applyStimulus("post_r5", encI(3'd5, 8'h00, 3'd0, 2'd1), 2, 16'h0000, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bitty_core_p.md
# bitty_core_p

Parametrised multi-cycle Bitty execution core. It is the next generation of the 16-bit Bitty processor datapath, with configurable data width and memory/PC widths. It adds an explicit instruction handshake, a program counter with conditional branches, and a generic request/acknowledge memory port in place of the hard-wired UART load/store path. It sits between the instruction source (ROM or UART loader) and the memory/peripheral fabric.

## Interface
- DATA_W, 16, register/ALU/memory data width; legal range 8..32
- ADDR_W, 8, memory address width; legal range 1..DATA_W
- PC_W, 8, program counter width; legal range 8..16
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- instr  in  16  instruction word; sampled on accept
- instr_valid  in  1  instr is valid
- instr_ready  out  1  core can accept an instruction; high only in FETCH
- pc  out  PC_W  address of the instruction to fetch
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = store, 0 = load; valid with mem_req
- mem_addr  out  ADDR_W  registers[Ry][ADDR_W-1:0]
- mem_wdata  out  DATA_W  registers[Rx]; valid with mem_req
- mem_rdata  in  DATA_W  load data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion strobe
- d_out  out  DATA_W  last written-back value; registered
- done  out  1  one-cycle pulse in WB

## Operation
- Register file: 8 x DATA_W registers r0..r7, all writable. Rx = instr[15:13], Ry = instr[12:10], imm8 = instr[12:5], sel = instr[4:2], fmt = instr[1:0].
- fmt 0, register ALU: Rx <= Rx op Ry.
- fmt 1, immediate ALU: Rx <= Rx op zero-extend(imm8).
- fmt 2, branch: cond = sel. 0 always; 1 if Rx==0; 2 if Rx!=0; 3 if Rx[DATA_W-1]; 4..7 never taken. Taken: pc <= pc + sign-extend(imm8), modulo 2^PC_W. Not taken: pc+1. No register write; d_out unchanged.
- fmt 3, load/store: sel[0]=1 store mem[Ry] <= Rx, d_out <= Rx. sel[0]=0 load Rx <= mem_rdata, d_out <= mem_rdata.
- ALU ops (sel): 0 add; 1 sub; 2 and; 3 or; 4 xor; 5 shl; 6 shr (logical); 7 sltu (1 if a<b unsigned, else 0). Results are truncated to DATA_W. Shift amount = b[$clog2(DATA_W)-1:0].
- All non-branch instructions set pc <= pc+1 (wraps) at the WB edge.
- FSM states and transitions:
  - FETCH to EXEC on instr_valid && instr_ready; instr, operands and pc are latched.
  - EXEC to MEM if fmt 3, else to WB. The ALU result or branch target is registered in EXEC.
  - MEM holds mem_req/mem_we/mem_addr/mem_wdata stable; goes to WB on mem_ack. Load data is captured in the ack cycle.
  - WB: done=1, register/d_out/pc update at the end of the cycle, then to FETCH.
- mem_ack outside MEM is ignored. instr_valid outside FETCH is ignored.
- Reset (any state, including mid-MEM): all registers, pc, d_out = 0; state = FETCH. mem_req, mem_we, done deassert immediately. instr_ready = 1 after reset release. mem_addr/mem_wdata = 0.

## Timing
- Accept at edge 0 → EXEC cycle 1 → WB cycle 2 (done=1) → FETCH cycle 3. Non-memory instructions take 3 cycles each.
- Memory instructions: EXEC cycle 1, MEM from cycle 2 with mem_req=1. If mem_ack arrives in cycle 2+k, WB is cycle 3+k. The minimum is 4 cycles per instruction.
- A written register is visible to the next accepted instruction; there are no hazards.
- pc is stable from the WB edge through the whole FETCH state.

## Test plan
- DATA_W=16. Instructions: r1 += imm 0x05, then r2 += imm 0xFF, then r1 = r1 + r2 (fmt 0, sel 0). Expected: done pulses every 3 cycles; d_out 0x0005, 0x00FF, then 0x0104; pc 1, 2, 3.
- DATA_W=8, r3=0xF0. sub r3 - imm 0xF1 gives 0xFF. Then shl by imm 9 (amount 1) gives 0xFE. Then sltu 0xFE < imm 0xFF gives 0x01.
- Branch with pc=0x02, r4=0. Cond 1 with imm8=0xFE: pc becomes 0x00. Cond 2 with the same imm: pc becomes 0x03. Cond 0 with imm 0x7F at pc=0xF0 (PC_W=8): pc becomes 0x6F (wrap).
- Store r5=0xBEEF to r6=0x12: mem_req/mem_we held 1 with addr 0x12 and wdata 0xBEEF through a 3-cycle ack delay; done follows 1 cycle after ack. Then load from 0x12 with rdata 0xBEEF into r7 and read back via add r7 + imm 0: d_out = 0xBEEF.
- Assert reset during MEM before ack: mem_req drops the same cycle. After release, pc=0, d_out=0, instr_ready=1. A stray mem_ack is ignored.
- Hold instr_valid=0 for 5 cycles in FETCH: state, pc and registers are unchanged, and done stays 0.
